// File: rtl/vga_text_render_if.sv
// CPU-side cell write / clear port of the text renderer.
//   wr_en   : write one cell (wr_row, wr_col) with wr_char
//   wr_row  : target text row
//   wr_col  : target text column
//   wr_char : ASCII code to store
//   clr     : pulse, fill every cell with a space
//   busy    : clear sweep in progress (driven by the renderer)
interface vga_text_render_if #(
    parameter int unsigned ROWS = 3,
    parameter int unsigned COLS = 12
);
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic             wr_en;
    logic [ROW_W-1:0] wr_row;
    logic [COL_W-1:0] wr_col;
    logic [7:0]       wr_char;
    logic             clr;
    logic             busy;

    modport master (output wr_en, wr_row, wr_col, wr_char, clr, input busy);
    modport slave  (input wr_en, wr_row, wr_col, wr_char, clr, output busy);
endinterface

// File: rtl/vga_text_render.sv
// ROWS x COLS character-grid renderer for the VGA output path.
// Ports:
//   clk, rst_n          : pixel clock, asynchronous active-low reset
//   pixel_x, pixel_y    : current pixel position from the sync generator
//   video_on            : visible-area flag
//   cpu                 : cell write / clear port (vga_text_render_if.slave)
//   cursor_en           : enable the blinking inverted cursor
//   cur_row, cur_col    : cursor cell
//   font_ascii, font_col: glyph select to the external font ROM (registered)
//   font_bits           : combinational column pattern from the font ROM, bit 6 = top
//   vga_r, vga_g, vga_b : registered colour, 3 clocks after pixel_x/pixel_y
module vga_text_render #(
    parameter int unsigned COLS         = 12,
    parameter int unsigned ROWS         = 3,
    parameter int unsigned SCALE_X      = 10,
    parameter int unsigned SCALE_Y      = 10,
    parameter int unsigned GAP_X        = 3,
    parameter int unsigned GAP_Y        = 60,
    parameter int unsigned X0           = 5,
    parameter int unsigned Y0           = 41,
    parameter logic [11:0] FG_COLOR     = 12'hFFF,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter int unsigned BLINK_FRAMES = 30,
    localparam int unsigned ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned COL_W       = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    input  logic             video_on,
    vga_text_render_if.slave cpu,
    input  logic             cursor_en,
    input  logic [ROW_W-1:0] cur_row,
    input  logic [COL_W-1:0] cur_col,
    output logic [7:0]       font_ascii,
    output logic [2:0]       font_col,
    input  logic [6:0]       font_bits,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b
);
    localparam int unsigned GLYPH_W = 5 * SCALE_X;
    localparam int unsigned GLYPH_H = 7 * SCALE_Y;
    localparam int unsigned CELL_W  = GLYPH_W + GAP_X;
    localparam int unsigned ROW_H   = GLYPH_H + GAP_Y;
    localparam int unsigned CELLS   = ROWS * COLS;
    localparam int unsigned ADDR_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    // Geometry decode; the >= guards keep pixels left/above the origin from wrapping into the grid
    logic              x_ok_c, y_ok_c, in_glyph_c;
    logic [9:0]        dx_c, dy_c, cx_c, cy_c, gx_c, gy_c;
    logic [ADDR_W-1:0] cell_c;
    logic [2:0]        gcol_c, grow_c;

    always_comb begin
        x_ok_c     = pixel_x >= 10'(X0);
        y_ok_c     = pixel_y >= 10'(Y0);
        dx_c       = pixel_x - 10'(X0);
        dy_c       = pixel_y - 10'(Y0);
        cx_c       = dx_c / 10'(CELL_W);
        cy_c       = dy_c / 10'(ROW_H);
        gx_c       = dx_c % 10'(CELL_W);
        gy_c       = dy_c % 10'(ROW_H);
        in_glyph_c = x_ok_c && y_ok_c && (cx_c < 10'(COLS)) && (cy_c < 10'(ROWS)) &&
                     (gx_c < 10'(GLYPH_W)) && (gy_c < 10'(GLYPH_H));
        // Zeroed outside a glyph so the RAM read and font_bits index stay in range
        cell_c     = '0;
        gcol_c     = '0;
        grow_c     = '0;
        if (in_glyph_c) begin
            cell_c = ADDR_W'(cy_c) * ADDR_W'(COLS) + ADDR_W'(cx_c);
            gcol_c = 3'(gx_c / 10'(SCALE_X));
            grow_c = 3'(gy_c / 10'(SCALE_Y));
        end
    end

    // Character RAM, no reset
    logic [7:0]        mem [CELLS];
    logic              ram_we_c;
    logic [ADDR_W-1:0] ram_waddr_c;
    logic [7:0]        ram_wdata_c;

    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            mem[ram_waddr_c] <= ram_wdata_c;
        end
    end

    // Clear sweep FSM
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              busy_q, busy_d;
    logic              wr_ok_c;
    logic [ADDR_W-1:0] wr_addr_c;

    always_comb begin
        wr_ok_c   = (32'(cpu.wr_row) < ROWS) && (32'(cpu.wr_col) < COLS);
        wr_addr_c = ADDR_W'(cpu.wr_row) * ADDR_W'(COLS) + ADDR_W'(cpu.wr_col);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        busy_d      = busy_q;
        ram_we_c    = 1'b0;
        ram_waddr_c = clr_addr_q;
        ram_wdata_c = 8'h20;
        case (state_q)
            ST_IDLE: begin
                // clr has priority; a simultaneous write is dropped
                if (cpu.clr) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                    busy_d     = 1'b1;
                end else if (cpu.wr_en && wr_ok_c) begin
                    ram_we_c    = 1'b1;
                    ram_waddr_c = wr_addr_c;
                    ram_wdata_c = cpu.wr_char;
                end
            end
            ST_CLEAR: begin
                ram_we_c = 1'b1;
                if (clr_addr_q == ADDR_W'(CELLS - 1)) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                    busy_d     = 1'b0;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cpu.busy = busy_q;

    // Cursor blink: count rising edges of the (0,0) pixel
    logic             fs_c, fs_q, blink_q;
    logic [CNT_W-1:0] frame_q;

    assign fs_c = (pixel_x == 10'd0) && (pixel_y == 10'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fs_q    <= 1'b0;
            frame_q <= '0;
            blink_q <= 1'b1;
        end else begin
            fs_q <= fs_c;
            if (fs_c && !fs_q) begin
                if (frame_q == CNT_W'(BLINK_FRAMES - 1)) begin
                    frame_q <= '0;
                    blink_q <= ~blink_q;
                end else begin
                    frame_q <= frame_q + CNT_W'(1);
                end
            end
        end
    end

    // Three-stage pixel pipeline
    logic              s1_in_glyph, s1_von;
    logic [ADDR_W-1:0] s1_cell;
    logic [2:0]        s1_gcol, s1_grow;
    logic              s2_in_glyph, s2_von, s2_inv;
    logic [2:0]        s2_grow;
    logic [11:0]       rgb_q;
    logic [ADDR_W-1:0] cur_cell_c;
    logic              pix_c;

    assign cur_cell_c = ADDR_W'(cur_row) * ADDR_W'(COLS) + ADDR_W'(cur_col);
    assign pix_c      = font_bits[3'd6 - s2_grow] ^ s2_inv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_in_glyph <= 1'b0;
            s1_von      <= 1'b0;
            s1_cell     <= '0;
            s1_gcol     <= '0;
            s1_grow     <= '0;
            font_ascii  <= '0;
            font_col    <= '0;
            s2_in_glyph <= 1'b0;
            s2_von      <= 1'b0;
            s2_inv      <= 1'b0;
            s2_grow     <= '0;
            rgb_q       <= '0;
        end else begin
            s1_in_glyph <= in_glyph_c;
            s1_von      <= video_on;
            s1_cell     <= cell_c;
            s1_gcol     <= gcol_c;
            s1_grow     <= grow_c;
            font_ascii  <= mem[s1_cell];
            font_col    <= s1_gcol;
            s2_in_glyph <= s1_in_glyph;
            s2_von      <= s1_von;
            s2_inv      <= cursor_en && blink_q && (s1_cell == cur_cell_c);
            s2_grow     <= s1_grow;
            rgb_q       <= (s2_von && s2_in_glyph && pix_c) ? FG_COLOR : BG_COLOR;
        end
    end

    assign vga_r = rgb_q[11:8];
    assign vga_g = rgb_q[7:4];
    assign vga_b = rgb_q[3:0];
endmodule
